// File: rtl/id_ex_stage_pkg.sv
// alu_consts: shared encodings for the decode/execute boundary.
//   ALUOP_*  : 4-bit ALU opcodes carried from decode to the ALU
//   A_SEL_*  : ALU A-operand source select (2 bits)
//   B_SEL_*  : ALU B-operand source select (1 bit)
//   XLEN_DEFAULT : default datapath width
package alu_consts;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALUOP_ADD  = 4'd0,
        ALUOP_SUB  = 4'd1,
        ALUOP_AND  = 4'd2,
        ALUOP_OR   = 4'd3,
        ALUOP_XOR  = 4'd4,
        ALUOP_SLL  = 4'd5,
        ALUOP_SRL  = 4'd6,
        ALUOP_SRA  = 4'd7,
        ALUOP_SLT  = 4'd8,
        ALUOP_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2,
        A_SEL_RSVD = 2'd3
    } a_sel_e;

    typedef enum logic {
        B_SEL_RS2 = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: combinational priority forwarder for one source operand.
//   idx        : register index being read
//   rf_data    : register-file read data (fallback)
//   ex_en/ex_rd/ex_result    : EX-stage candidate (highest priority)
//   mem_en/mem_rd/mem_result : MEM-stage candidate
//   wb_en/wb_rd/wb_result    : WB-stage candidate (lowest priority)
//   value      : resolved operand; x0 always reads as zero
module fwd_mux #(
    parameter int XLEN      = alu_consts::XLEN_DEFAULT,
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [XLEN-1:0]      rf_data,
    input  logic                 ex_en,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [XLEN-1:0]      ex_result,
    input  logic                 mem_en,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]      mem_result,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_result,
    output logic [XLEN-1:0]      value
);

    always_comb begin
        value = rf_data;
        if (idx == '0) begin
            value = '0;
        end else if (ex_en && ex_rd == idx) begin
            value = ex_result;
        end else if (mem_en && mem_rd == idx) begin
            value = mem_result;
        end else if (wb_en && wb_rd == idx) begin
            value = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register in front of the ALU.
//   in_*            : decoded instruction, register-file data and control
//   in_ready        : instruction accepted this cycle
//   ex_alu_result   : ALU result of the instruction currently held here
//   mem_*/wb_*      : downstream writeback info for forwarding
//   stall/flush     : downstream hold and branch/trap kill
//   ex_*            : registered ALU operands, op and destination/control
//   bubble_cnt      : saturating count of load-use bubbles
module id_ex_stage
    import alu_consts::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  logic                 in_uses_rs1,
    input  logic                 in_uses_rs2,
    input  logic [XLEN-1:0]      in_rs1_data,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [3:0]           in_alu_op,
    input  logic [1:0]           in_a_sel,
    input  logic                 in_b_sel,
    input  logic                 in_reg_write,
    input  logic                 in_mem_read,
    input  logic                 in_mem_write,
    input  logic [XLEN-1:0]      ex_alu_result,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 mem_reg_write,
    input  logic                 wb_reg_write,
    input  logic [XLEN-1:0]      mem_result,
    input  logic [XLEN-1:0]      wb_result,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_a,
    output logic [XLEN-1:0]      ex_b,
    output logic [3:0]           ex_alu_op,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [XLEN-1:0]      ex_store_data,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic            ex_fwd_en;
    logic            load_use;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] a_val;
    logic [XLEN-1:0] b_val;

    // A load in EX has no data yet, so it must not be used as an EX forward;
    // the load-use bubble lets it be picked up from MEM one cycle later.
    assign ex_fwd_en = ex_valid & ex_reg_write & ~ex_mem_read;

    fwd_mux #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_rs1 (
        .idx        (in_rs1_idx),
        .rf_data    (in_rs1_data),
        .ex_en      (ex_fwd_en),
        .ex_rd      (ex_rd),
        .ex_result  (ex_alu_result),
        .mem_en     (mem_reg_write),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .wb_en      (wb_reg_write),
        .wb_rd      (wb_rd),
        .wb_result  (wb_result),
        .value      (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_rs2 (
        .idx        (in_rs2_idx),
        .rf_data    (in_rs2_data),
        .ex_en      (ex_fwd_en),
        .ex_rd      (ex_rd),
        .ex_result  (ex_alu_result),
        .mem_en     (mem_reg_write),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .wb_en      (wb_reg_write),
        .wb_rd      (wb_rd),
        .wb_result  (wb_result),
        .value      (rs2_fwd)
    );

    always_comb begin
        a_val = '0;
        case (in_a_sel)
            A_SEL_RS1: a_val = rs1_fwd;
            A_SEL_PC:  a_val = in_pc;
            default:   a_val = '0;
        endcase
    end

    assign b_val = (in_b_sel == B_SEL_IMM) ? in_imm : rs2_fwd;

    assign load_use = in_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((in_uses_rs1 & (in_rs1_idx == ex_rd)) |
                       (in_uses_rs2 & (in_rs2_idx == ex_rd)));

    assign in_ready = ~stall & ~load_use & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_alu_op     <= ALUOP_ADD;
            ex_rd         <= '0;
            ex_store_data <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            bubble_cnt    <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (load_use) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            if (bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else if (in_valid) begin
            ex_valid      <= 1'b1;
            ex_pc         <= in_pc;
            ex_a          <= a_val;
            ex_b          <= b_val;
            ex_alu_op     <= in_alu_op;
            ex_rd         <= in_rd_idx;
            ex_store_data <= rs2_fwd;
            ex_reg_write  <= in_reg_write;
            ex_mem_read   <= in_mem_read;
            ex_mem_write  <= in_mem_write;
        end else begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import alu_consts::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int CW   = 16;

    logic            clk, reset;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [RW-1:0]   in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic            in_uses_rs1, in_uses_rs2;
    logic [3:0]      in_alu_op;
    logic [1:0]      in_a_sel;
    logic            in_b_sel;
    logic            in_reg_write, in_mem_read, in_mem_write;
    logic [XLEN-1:0] ex_alu_result, mem_result, wb_result;
    logic [RW-1:0]   mem_rd, wb_rd;
    logic            mem_reg_write, wb_reg_write;
    logic            stall, flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [3:0]      ex_alu_op;
    logic [RW-1:0]   ex_rd;
    logic            ex_reg_write, ex_mem_read, ex_mem_write;
    logic [CW-1:0]   bubble_cnt;

    // second instance with a 2-bit counter to reach saturation quickly
    logic            s_in_ready, s_ex_valid;
    logic [XLEN-1:0] s_ex_pc, s_ex_a, s_ex_b, s_ex_store_data;
    logic [3:0]      s_ex_alu_op;
    logic [RW-1:0]   s_ex_rd;
    logic            s_ex_reg_write, s_ex_mem_read, s_ex_mem_write;
    logic [1:0]      s_bubble_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.XLEN(XLEN), .REG_IDX_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rd_idx(in_rd_idx), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_result(mem_result), .wb_result(wb_result), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.XLEN(XLEN), .REG_IDX_W(RW), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rd_idx(in_rd_idx), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_result(mem_result), .wb_result(wb_result), .stall(stall), .flush(flush),
        .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_a(s_ex_a), .ex_b(s_ex_b),
        .ex_alu_op(s_ex_alu_op), .ex_rd(s_ex_rd), .ex_store_data(s_ex_store_data),
        .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
        .ex_mem_write(s_ex_mem_write), .bubble_cnt(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic clr_in();
        in_valid = 0; in_pc = '0; in_rs1_idx = '0; in_rs2_idx = '0; in_rd_idx = '0;
        in_uses_rs1 = 0; in_uses_rs2 = 0; in_rs1_data = '0; in_rs2_data = '0;
        in_imm = '0; in_alu_op = ALUOP_ADD; in_a_sel = A_SEL_RS1; in_b_sel = B_SEL_RS2;
        in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
        mem_rd = '0; wb_rd = '0; mem_reg_write = 0; wb_reg_write = 0;
        mem_result = '0; wb_result = '0; stall = 0; flush = 0;
    endtask

    task automatic test_reset();
        reset = 1; ex_alu_result = '0;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ex_valid); end
        total++; if (ex_a !== '0 || ex_b !== '0 || ex_pc !== '0) begin bad++; $display("FAIL rst_data got a=%h b=%h pc=%h want 0", ex_a, ex_b, ex_pc); end
        total++; if (ex_alu_op !== ALUOP_ADD) begin bad++; $display("FAIL rst_op got=%h want=0", ex_alu_op); end
        total++; if (bubble_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", bubble_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", in_ready); end
        @(negedge clk); reset = 0;
    endtask

    task automatic test_ex_forward();
        // add x5 = x1 + x2
        @(negedge clk); clr_in();
        in_valid = 1; in_rd_idx = 5; in_reg_write = 1; in_rs1_idx = 1; in_rs1_data = 32'h8;
        in_rs2_idx = 2; in_rs2_data = 32'h8; in_uses_rs1 = 1; in_uses_rs2 = 1;
        @(posedge clk); #1;
        total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_a !== 32'h8) begin bad++; $display("FAIL add_issue got v=%b rd=%0d a=%h want v=1 rd=5 a=8", ex_valid, ex_rd, ex_a); end
        ex_alu_result = 32'h10;
        // sub x6 = x5 - x3, EX forward
        @(negedge clk); clr_in();
        in_valid = 1; in_rd_idx = 6; in_reg_write = 1; in_alu_op = ALUOP_SUB;
        in_rs1_idx = 5; in_rs1_data = 32'h0; in_rs2_idx = 3; in_rs2_data = 32'h7;
        in_uses_rs1 = 1; in_uses_rs2 = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        total++; if (ex_a !== 32'h10 || ex_b !== 32'h7 || ex_alu_op !== ALUOP_SUB) begin bad++; $display("FAIL ex_fwd got a=%h b=%h op=%h want a=10 b=7 op=1", ex_a, ex_b, ex_alu_op); end
        ex_alu_result = 32'h9;
        // add x5 again, then sub with MEM also writing x5: EX must win
        @(negedge clk); clr_in();
        in_valid = 1; in_rd_idx = 5; in_reg_write = 1; in_rs1_idx = 1; in_rs1_data = 32'h8;
        @(posedge clk); #1;
        ex_alu_result = 32'h10;
        @(negedge clk); clr_in();
        in_valid = 1; in_rd_idx = 6; in_reg_write = 1; in_alu_op = ALUOP_SUB;
        in_rs1_idx = 5; in_rs1_data = 32'h0; in_uses_rs1 = 1;
        mem_reg_write = 1; mem_rd = 5; mem_result = 32'h20;
        @(posedge clk); #1;
        total++; if (ex_a !== 32'h10) begin bad++; $display("FAIL ex_over_mem got=%h want=10", ex_a); end
        ex_alu_result = 32'h1234;
        // EX holds x6: rs2=x6 from EX; rs1=x5 from MEM beats WB
        @(negedge clk); clr_in();
        in_valid = 1; in_rs1_idx = 5; in_rs1_data = 32'h1; in_rs2_idx = 6; in_rs2_data = 32'h2;
        in_uses_rs1 = 1; in_uses_rs2 = 1;
        mem_reg_write = 1; mem_rd = 5; mem_result = 32'h20;
        wb_reg_write = 1; wb_rd = 5; wb_result = 32'h33;
        @(posedge clk); #1;
        total++; if (ex_a !== 32'h20) begin bad++; $display("FAIL mem_over_wb got=%h want=20", ex_a); end
        total++; if (ex_b !== 32'h1234 || ex_store_data !== 32'h1234) begin bad++; $display("FAIL ex_fwd_rs2 got b=%h sd=%h want 1234", ex_b, ex_store_data); end
        // WB only
        @(negedge clk); clr_in();
        in_valid = 1; in_rs1_idx = 5; in_rs1_data = 32'h1; in_uses_rs1 = 1;
        wb_reg_write = 1; wb_rd = 5; wb_result = 32'h33;
        @(posedge clk); #1;
        total++; if (ex_a !== 32'h33) begin bad++; $display("FAIL wb_fwd got=%h want=33", ex_a); end
    endtask

    task automatic test_load_use();
        // lw x7, 4(x1)
        @(negedge clk); clr_in();
        in_valid = 1; in_rd_idx = 7; in_reg_write = 1; in_mem_read = 1;
        in_rs1_idx = 1; in_rs1_data = 32'h1000; in_uses_rs1 = 1; in_b_sel = B_SEL_IMM; in_imm = 32'h4;
        @(posedge clk); #1;
        total++; if (ex_mem_read !== 1'b1 || ex_a !== 32'h1000 || ex_b !== 32'h4) begin bad++; $display("FAIL lw_issue got mr=%b a=%h b=%h want mr=1 a=1000 b=4", ex_mem_read, ex_a, ex_b); end
        ex_alu_result = 32'h1004;
        // add x10 = x1 + x7
        @(negedge clk); clr_in();
        in_valid = 1; in_rd_idx = 10; in_reg_write = 1; in_rs1_idx = 1; in_rs1_data = 32'h3;
        in_rs2_idx = 7; in_rs2_data = 32'h0; in_uses_rs1 = 1; in_uses_rs2 = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin bad++; $display("FAIL lu_bubble got v=%b rw=%b mr=%b want 0", ex_valid, ex_reg_write, ex_mem_read); end
        total++; if (bubble_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", bubble_cnt); end
        @(negedge clk);
        mem_reg_write = 1; mem_rd = 7; mem_result = 32'hDEADBEEF;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_ready2 got=%b want=1", in_ready); end
        @(posedge clk); #1;
        total++; if (ex_valid !== 1'b1 || ex_b !== 32'hDEADBEEF || ex_a !== 32'h3) begin bad++; $display("FAIL lu_mem_fwd got v=%b a=%h b=%h want v=1 a=3 b=deadbeef", ex_valid, ex_a, ex_b); end
    endtask

    task automatic test_x0();
        @(negedge clk); clr_in();
        in_valid = 1; in_rs1_idx = 0; in_rs1_data = 32'h77; in_uses_rs1 = 1;
        in_rs2_idx = 0; in_rs2_data = 32'h88; in_uses_rs2 = 1;
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'h55;
        wb_reg_write = 1; wb_rd = 0; wb_result = 32'h66;
        @(posedge clk); #1;
        total++; if (ex_a !== '0 || ex_b !== '0 || ex_store_data !== '0) begin bad++; $display("FAIL x0_zero got a=%h b=%h sd=%h want 0", ex_a, ex_b, ex_store_data); end
    endtask

    task automatic test_stall_flush();
        @(negedge clk); clr_in();
        in_valid = 1; in_pc = 32'h200; in_rd_idx = 3; in_reg_write = 1; in_alu_op = ALUOP_AND;
        @(posedge clk); #1;
        total++; if (ex_pc !== 32'h200 || ex_alu_op !== ALUOP_AND) begin bad++; $display("FAIL sf_issue got pc=%h op=%h want pc=200 op=2", ex_pc, ex_alu_op); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clr_in();
            in_valid = 1; in_pc = 32'h300; in_rd_idx = 4; in_reg_write = 1; stall = 1;
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0", i, in_ready); end
            @(posedge clk); #1;
            total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_rd !== 5'd3 || ex_alu_op !== ALUOP_AND) begin bad++; $display("FAIL stall_hold[%0d] got v=%b pc=%h rd=%0d want v=1 pc=200 rd=3", i, ex_valid, ex_pc, ex_rd); end
        end
        @(negedge clk); flush = 1; stall = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin bad++; $display("FAIL flush_stall got v=%b rw=%b want 0", ex_valid, ex_reg_write); end
        // flush while load_use is pending: no count
        @(negedge clk); clr_in();
        in_valid = 1; in_rd_idx = 8; in_reg_write = 1; in_mem_read = 1;
        @(posedge clk); #1;
        @(negedge clk); clr_in();
        in_valid = 1; in_rs1_idx = 8; in_uses_rs1 = 1; flush = 1;
        @(posedge clk); #1;
        total++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || bubble_cnt !== 16'd1) begin bad++; $display("FAIL flush_lu got v=%b mr=%b cnt=%0d want v=0 mr=0 cnt=1", ex_valid, ex_mem_read, bubble_cnt); end
        @(negedge clk); clr_in();
        @(posedge clk); #1;
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin bad++; $display("FAIL idle_bubble got v=%b rw=%b want 0", ex_valid, ex_reg_write); end
    endtask

    task automatic test_sel();
        @(negedge clk); clr_in();
        in_valid = 1; in_a_sel = A_SEL_PC; in_b_sel = B_SEL_IMM; in_pc = 32'h100; in_imm = 32'h4;
        in_rs1_idx = 1; in_rs1_data = 32'hAAAA; in_rs2_idx = 2; in_rs2_data = 32'h5555;
        in_uses_rs1 = 1; in_uses_rs2 = 1;
        @(posedge clk); #1;
        total++; if (ex_a !== 32'h100 || ex_b !== 32'h4 || ex_store_data !== 32'h5555) begin bad++; $display("FAIL sel_pc_imm got a=%h b=%h sd=%h want a=100 b=4 sd=5555", ex_a, ex_b, ex_store_data); end
        @(negedge clk); in_a_sel = A_SEL_RSVD; in_b_sel = B_SEL_RS2;
        @(posedge clk); #1;
        total++; if (ex_a !== '0 || ex_b !== 32'h5555) begin bad++; $display("FAIL sel_rsvd got a=%h b=%h want a=0 b=5555", ex_a, ex_b); end
        @(negedge clk); in_a_sel = A_SEL_ZERO;
        @(posedge clk); #1;
        total++; if (ex_a !== '0) begin bad++; $display("FAIL sel_zero got a=%h want 0", ex_a); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clr_in();
            in_valid = 1; in_rd_idx = 7; in_reg_write = 1; in_mem_read = 1;
            @(posedge clk); #1;
            @(negedge clk); clr_in();
            in_valid = 1; in_rd_idx = 9; in_reg_write = 1; in_rs2_idx = 7; in_uses_rs2 = 1;
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sat_ready[%0d] got=%b want=0", i, in_ready); end
            @(posedge clk); #1;
            @(negedge clk); mem_reg_write = 1; mem_rd = 7; mem_result = 32'h42;
            @(posedge clk); #1;
        end
        total++; if (bubble_cnt !== 16'd5) begin bad++; $display("FAIL cnt_main got=%0d want=5", bubble_cnt); end
        total++; if (s_bubble_cnt !== 2'd3) begin bad++; $display("FAIL cnt_sat got=%0d want=3", s_bubble_cnt); end
        total++; if (ex_valid !== 1'b1 || ex_b !== 32'h42) begin bad++; $display("FAIL sat_fwd got v=%b b=%h want v=1 b=42", ex_valid, ex_b); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); clr_in();
        in_valid = 1; in_rd_idx = 11; in_reg_write = 1; in_alu_op = ALUOP_XOR; in_pc = 32'h500;
        @(posedge clk); #3;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL pre_reset got v=%b want=1", ex_valid); end
        reset = 1;
        #1;
        total++; if (ex_valid !== 1'b0 || ex_pc !== '0 || ex_rd !== '0 || ex_reg_write !== 1'b0) begin bad++; $display("FAIL mid_reset got v=%b pc=%h rd=%0d rw=%b want 0", ex_valid, ex_pc, ex_rd, ex_reg_write); end
        total++; if (ex_alu_op !== ALUOP_ADD || bubble_cnt !== '0 || s_bubble_cnt !== '0) begin bad++; $display("FAIL mid_reset_op got op=%h cnt=%0d want op=0 cnt=0", ex_alu_op, bubble_cnt); end
        @(negedge clk); reset = 0;
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_load_use();
        test_x0();
        test_stall_flush();
        test_sel();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
